// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : shared source ids and FSM state encodings for the mux datapath
// Revision: 1.0
// ============================================================================
package mux_pkg;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_A = 2'd1,
    ST_HOLD_B = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : combinational 2-way round-robin grant (one-hot or zero)
// Revision: 1.0
// ============================================================================
module rr_arb2
  import mux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie, favour the channel that did not win last time
      2'b11:   gnt = (last_grant == SRC_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// mux_rr_arbiter : round-robin 2:1 valid/ready sequencer with registered output
// Revision: 1.0
// ============================================================================
module mux_rr_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A_in,
  input  logic             A_valid,
  output logic             A_ready,
  input  logic [WIDTH-1:0] B_in,
  input  logic             B_valid,
  output logic             B_ready,
  output logic             Select,
  output logic [WIDTH-1:0] Y_out,
  output logic             Y_valid,
  input  logic             Y_ready,
  output logic [CNT_W-1:0] A_count,
  output logic [CNT_W-1:0] B_count
);

  state_t     state;
  state_t     state_next;
  logic       last_grant;
  logic       free;
  logic [1:0] gnt;
  logic       accept;

  rr_arb2 u_arb (
    .req        ({B_valid, A_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign Y_valid = (state != ST_IDLE);
  assign free    = !Y_valid || Y_ready;
  assign accept  = !Reset && free && (gnt != 2'b00);
  assign A_ready = !Reset && free && gnt[0];
  assign B_ready = !Reset && free && gnt[1];

  always_comb begin
    state_next = state;
    if (free) begin
      if (gnt[0])      state_next = ST_HOLD_A;
      else if (gnt[1]) state_next = ST_HOLD_B;
      else             state_next = ST_IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Data, select and counters only move on an accepting edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Y_out      <= '0;
      Select     <= SRC_A;
      last_grant <= SRC_B;
      A_count    <= '0;
      B_count    <= '0;
    end else if (accept) begin
      Y_out      <= gnt[1] ? B_in : A_in;
      Select     <= gnt[1];
      last_grant <= gnt[1];
      if (gnt[1]) B_count <= B_count + CNT_W'(1);
      else        A_count <= A_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_arbiter : directed self-checking bench for mux_rr_arbiter
// Revision: 1.0
// ============================================================================
module tb_mux_rr_arbiter;

  logic       Clk;
  logic       Reset;
  logic [1:0] A_in, B_in;
  logic       A_valid, B_valid, Y_ready;
  logic       A_ready, B_ready, Select, Y_valid;
  logic [1:0] Y_out;
  logic [7:0] A_count, B_count;
  logic       s_A_ready, s_B_ready, s_Select, s_Y_valid;
  logic [1:0] s_Y_out;
  logic [1:0] s_A_count, s_B_count;

  int checks   = 0;
  int failures = 0;

  mux_rr_arbiter #(.WIDTH(2), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_in(A_in), .A_valid(A_valid), .A_ready(A_ready),
    .B_in(B_in), .B_valid(B_valid), .B_ready(B_ready),
    .Select(Select), .Y_out(Y_out), .Y_valid(Y_valid), .Y_ready(Y_ready),
    .A_count(A_count), .B_count(B_count)
  );

  // Narrow-counter instance shares stimulus, used for wrap-around checks
  mux_rr_arbiter #(.WIDTH(2), .CNT_W(2)) dut_small (
    .Clk(Clk), .Reset(Reset),
    .A_in(A_in), .A_valid(A_valid), .A_ready(s_A_ready),
    .B_in(B_in), .B_valid(B_valid), .B_ready(s_B_ready),
    .Select(s_Select), .Y_out(s_Y_out), .Y_valid(s_Y_valid), .Y_ready(Y_ready),
    .A_count(s_A_count), .B_count(s_B_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  logic [1:0] seq_small [5];

  initial begin
    Reset = 1'b1; A_in = 2'b10; B_in = 2'b00;
    A_valid = 1'b1; B_valid = 1'b0; Y_ready = 1'b0;

    // Reset held with A_valid asserted
    step(); step();
    check("rst_y_valid", Y_valid, 0);
    check("rst_select",  Select,  0);
    check("rst_y_out",   Y_out,   0);
    check("rst_a_ready", A_ready, 0);
    check("rst_a_count", A_count, 0);
    check("rst_b_count", B_count, 0);

    // Single A transfer
    Reset = 1'b0; A_in = 2'b10; A_valid = 1'b1; Y_ready = 1'b1;
    #1;
    check("single_a_ready", A_ready, 1);
    check("single_b_ready", B_ready, 0);
    step();
    A_valid = 1'b0;
    check("single_y_out",   Y_out,   2'b10);
    check("single_select",  Select,  0);
    check("single_y_valid", Y_valid, 1);
    check("single_a_count", A_count, 1);
    step();
    check("drain_y_valid", Y_valid, 0);
    check("drain_y_hold",  Y_out,   2'b10);

    // Alternation from a fresh reset: first tie goes to A
    do_reset();
    A_in = 2'b01; B_in = 2'b11; A_valid = 1'b1; B_valid = 1'b1; Y_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("alt_a_ready", A_ready, (i % 2 == 0) ? 1 : 0);
      check("alt_b_ready", B_ready, (i % 2 == 1) ? 1 : 0);
      step();
      check("alt_select", Select, (i % 2 == 1) ? 1 : 0);
      check("alt_y_out",  Y_out,  (i % 2 == 1) ? 2'b11 : 2'b01);
    end
    A_valid = 1'b0; B_valid = 1'b0;
    check("alt_a_count", A_count, 3);
    check("alt_b_count", B_count, 3);
    step();
    check("alt_drain", Y_valid, 0);

    // Backpressure: hold B word 2'b11 while A waits
    B_in = 2'b11; B_valid = 1'b1; Y_ready = 1'b1;
    step();
    B_valid = 1'b0; Y_ready = 1'b0; A_valid = 1'b1;
    check("bp_load_y_out", Y_out, 2'b11);
    for (int i = 0; i < 3; i++) begin
      A_in = 2'(i);
      #1;
      check("bp_a_ready", A_ready, 0);
      check("bp_b_ready", B_ready, 0);
      step();
      check("bp_y_out",   Y_out,   2'b11);
      check("bp_select",  Select,  1);
      check("bp_y_valid", Y_valid, 1);
    end
    A_in = 2'b10; Y_ready = 1'b1;
    #1;
    check("bp_rel_a_ready", A_ready, 1);
    step();
    A_valid = 1'b0;
    check("bp_rel_y_out",  Y_out,  2'b10);
    check("bp_rel_select", Select, 0);
    check("bp_a_count",    A_count, 4);
    check("bp_b_count",    B_count, 4);
    step();

    // Counter wrap on the 2-bit instance
    do_reset();
    seq_small[0] = 2'd1; seq_small[1] = 2'd2; seq_small[2] = 2'd3;
    seq_small[3] = 2'd0; seq_small[4] = 2'd1;
    A_in = 2'b01; A_valid = 1'b1; Y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wrap_small_a_count", s_A_count, seq_small[i]);
      check("wrap_big_a_count",   A_count,   i + 1);
    end
    A_valid = 1'b0;
    step();

    // Reset while a word is held under backpressure
    A_in = 2'b11; A_valid = 1'b1; Y_ready = 1'b1;
    step();
    A_valid = 1'b0; Y_ready = 1'b0;
    check("mid_pre_y_valid", Y_valid, 1);
    A_valid = 1'b1; Reset = 1'b1;
    Y_ready = 1'b1;
    #1;
    check("mid_rst_a_ready", A_ready, 0);
    Y_ready = 1'b0;
    step();
    check("mid_rst_y_valid", Y_valid, 0);
    check("mid_rst_select",  Select,  0);
    check("mid_rst_a_count", A_count, 0);
    Reset = 1'b0; A_in = 2'b01; B_in = 2'b10;
    A_valid = 1'b1; B_valid = 1'b1; Y_ready = 1'b1;
    #1;
    check("mid_tie_a_ready", A_ready, 1);
    check("mid_tie_b_ready", B_ready, 0);
    step();
    check("mid_tie_select", Select, 0);
    check("mid_tie_y_out",  Y_out,  2'b01);
    A_valid = 1'b0; B_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
